// File: rtl/pulsegen_arbiter_if.sv
// Requester / generator signal bundle for pulsegen_arbiter.
// slave is the arbiter's view; master is the driving side (front-end plus generator).
interface pulsegen_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*CNT_W-1:0] req_cnt_i;
  logic                     sync_en_i;
  logic                     sync_tick_i;
  logic [NUM_REQ-1:0]       ack_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     err_o;
  logic                     busy_o;
  logic [IDX_W-1:0]         owner_o;
  logic                     pg_start_o;
  logic [CNT_W-1:0]         pg_cnt_o;
  logic                     pg_abort_o;
  logic                     pg_done_i;

  modport slave (
    input  req_i, req_cnt_i, sync_en_i, sync_tick_i, pg_done_i,
    output ack_o, done_o, err_o, busy_o, owner_o, pg_start_o, pg_cnt_o, pg_abort_o
  );

  modport master (
    output req_i, req_cnt_i, sync_en_i, sync_tick_i, pg_done_i,
    input  ack_o, done_o, err_o, busy_o, owner_o, pg_start_o, pg_cnt_o, pg_abort_o
  );
endinterface

// File: rtl/pulsegen_arbiter.sv
// Round-robin scheduler sharing one pulse generator between NUM_REQ requesters.
// Optional RUN-state watchdog is compiled in when PGARB_WDOG_EN is defined.
module pulsegen_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 32,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  pulsegen_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // Where a finished (or zero-length / aborted) grant goes next.
  localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || WDOG_CYCLES < 1) begin : g_param_chk
    $error("pulsegen_arbiter: illegal parameter set");
  end

  function automatic logic [IDX_W-1:0] rr_next(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  state_t             r_state;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_done;
  logic               r_start;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [GAP_W-1:0]   r_gap;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic [CNT_W-1:0]   w_cnt;

`ifdef PGARB_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0]    r_wdog;
  logic               r_err;
  logic               r_abort;
`endif

  assign w_any = |bus.req_i;
  assign w_win = rr_next(bus.req_i, r_ptr);
  assign w_cnt = bus.req_cnt_i[w_win*CNT_W +: CNT_W];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_ack   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_gap   <= '0;
`ifdef PGARB_WDOG_EN
      r_wdog  <= '0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
`endif
    end else begin
      r_ack   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
`ifdef PGARB_WDOG_EN
      r_err   <= 1'b0;
      r_abort <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_cnt   <= w_cnt;
            r_ack   <= onehot(w_win);
            // A zero-length pulse completes at grant time and never touches the generator.
            if (w_cnt == '0) begin
              r_done  <= onehot(w_win);
              r_gap   <= GAP_LAST;
              r_state <= S_AFTER;
            end else if (bus.sync_en_i) begin
              r_state <= S_SYNC;
            end else begin
              r_start <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_SYNC: begin
          if (bus.sync_tick_i) begin
            r_start <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
`ifdef PGARB_WDOG_EN
          r_wdog  <= '0;
`endif
        end
        S_RUN: begin
          if (bus.pg_done_i) begin
            r_done  <= onehot(r_owner);
            r_gap   <= GAP_LAST;
            r_state <= S_AFTER;
          end
`ifdef PGARB_WDOG_EN
          // Completion on the terminal cycle takes priority over the abort.
          else if (r_wdog == WD_LAST) begin
            r_done  <= onehot(r_owner);
            r_err   <= 1'b1;
            r_abort <= 1'b1;
            r_gap   <= GAP_LAST;
            r_state <= S_AFTER;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= S_IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.done_o     = r_done;
  assign bus.busy_o     = (r_state != S_IDLE);
  assign bus.owner_o    = r_owner;
  assign bus.pg_start_o = r_start;
  assign bus.pg_cnt_o   = r_cnt;
`ifdef PGARB_WDOG_EN
  assign bus.err_o      = r_err;
  assign bus.pg_abort_o = r_abort;
`else
  assign bus.err_o      = 1'b0;
  assign bus.pg_abort_o = 1'b0;
`endif
endmodule

// File: tb/tb_pulsegen_arbiter.sv
// Randomized self-checking bench for pulsegen_arbiter against a transaction-level model.
module tb_pulsegen_arbiter;
  localparam int NR  = 4;
  localparam int CW  = 32;
  localparam int GAP = 2;
  localparam int WD  = 16;

  logic clk;
  logic rst;

  pulsegen_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

  pulsegen_arbiter #(
    .NUM_REQ(NR), .CNT_W(CW), .GAP_CYCLES(GAP), .WDOG_CYCLES(WD)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr;
  int cur_w;
  logic [CW-1:0] cur_cnt;
  int gw;
  bit z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int w);
    return NR'(1) << w;
  endfunction

  // Round-robin rule: first requester above the last winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] mask);
    for (int off = 1; off <= NR; off++) begin
      if (mask[(m_ptr + off) % NR]) return (m_ptr + off) % NR;
    end
    return -1;
  endfunction

  // mode: 0 random count (some zero), 1 nonzero, 2 zero.
  // Returns at the LOAD cycle, or at the ack cycle for a zero-length grant.
  task automatic grant(input logic [NR-1:0] mask, input bit sync, input int gap_wait,
                       input int mode, output bit zero);
    logic [NR*CW-1:0] cnts;
    logic [CW-1:0] v;
    int k;
    for (int j = 0; j < NR; j++) begin
      if (mode == 2) v = '0;
      else if (mode == 1 || $urandom_range(0, 4) != 0) v = CW'($urandom_range(1, 40));
      else v = '0;
      cnts[j*CW +: CW] = v;
    end
    bus.req_i     = mask;
    bus.req_cnt_i = cnts;
    bus.sync_en_i = sync;
    for (int i = 1; i <= gap_wait; i++) begin
      tick();
      check("ack_in_gap", 64'(bus.ack_o), 64'(0));
      check("done_in_gap", 64'(bus.done_o), 64'(0));
      check("err_in_gap", 64'(bus.err_o), 64'(0));
      check("start_in_gap", 64'(bus.pg_start_o), 64'(0));
      check("busy_gap", 64'(bus.busy_o), 64'(i < gap_wait));
    end
    cur_w   = rr_pick(mask);
    m_ptr   = cur_w;
    cur_cnt = cnts[cur_w*CW +: CW];
    tick();
    check("ack", 64'(bus.ack_o), 64'(oh(cur_w)));
    check("owner", 64'(bus.owner_o), 64'(cur_w));
    check("busy_ack", 64'(bus.busy_o), 64'(1));
    check("pg_cnt", 64'(bus.pg_cnt_o), 64'(cur_cnt));
    zero = (cur_cnt == '0);
    if (zero) begin
      check("done_zero", 64'(bus.done_o), 64'(oh(cur_w)));
      check("start_zero", 64'(bus.pg_start_o), 64'(0));
    end else begin
      check("done_at_ack", 64'(bus.done_o), 64'(0));
      check("start_at_ack", 64'(bus.pg_start_o), 64'(!sync));
    end
    bus.req_i     = '0;
    bus.req_cnt_i = {$urandom, $urandom, $urandom, $urandom};
    bus.sync_en_i = 1'($urandom_range(0, 1));
    if (!zero && sync) begin
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) begin
        bus.pg_done_i = 1'($urandom_range(0, 1));
        bus.req_i     = NR'($urandom);
        tick();
        check("start_in_sync", 64'(bus.pg_start_o), 64'(0));
        check("done_in_sync", 64'(bus.done_o), 64'(0));
        check("busy_sync", 64'(bus.busy_o), 64'(1));
      end
      bus.req_i       = NR'($urandom);
      bus.pg_done_i   = 1'b0;
      bus.sync_tick_i = 1'b1;
      tick();
      bus.sync_tick_i = 1'b0;
      check("start_after_tick", 64'(bus.pg_start_o), 64'(1));
      check("pg_cnt_load", 64'(bus.pg_cnt_o), 64'(cur_cnt));
    end
  endtask

  // From the LOAD cycle: generator completes d cycles later; ends at the done_o cycle.
  task automatic run_to_done(input int d);
    bus.pg_done_i = 1'($urandom_range(0, 1));
    bus.req_i     = NR'($urandom);
    for (int i = 1; i <= d; i++) begin
      tick();
      check("done_in_run", 64'(bus.done_o), 64'(0));
      check("start_in_run", 64'(bus.pg_start_o), 64'(0));
      check("busy_run", 64'(bus.busy_o), 64'(1));
      check("err_in_run", 64'(bus.err_o), 64'(0));
      check("abort_in_run", 64'(bus.pg_abort_o), 64'(0));
      check("pg_cnt_run", 64'(bus.pg_cnt_o), 64'(cur_cnt));
      bus.pg_done_i = (i == d);
      bus.req_i     = NR'($urandom);
    end
    tick();
    check("done", 64'(bus.done_o), 64'(oh(cur_w)));
    check("err_at_done", 64'(bus.err_o), 64'(0));
    check("abort_at_done", 64'(bus.pg_abort_o), 64'(0));
    check("busy_after_done", 64'(bus.busy_o), 64'(GAP > 0));
    bus.pg_done_i = 1'b0;
    bus.req_i     = '0;
  endtask

  task automatic run_txn(input logic [NR-1:0] mask, input bit sync, input int gap_wait,
                         input int mode);
    bit zr;
    grant(mask, sync, gap_wait, mode, zr);
    if (!zr) run_to_done($urandom_range(1, 12));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(bus.ack_o), 64'(0));
    check({tag, "_done"}, 64'(bus.done_o), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
    check({tag, "_start"}, 64'(bus.pg_start_o), 64'(0));
    check({tag, "_cnt"}, 64'(bus.pg_cnt_o), 64'(0));
    check({tag, "_owner"}, 64'(bus.owner_o), 64'(0));
    check({tag, "_err"}, 64'(bus.err_o), 64'(0));
    check({tag, "_abort"}, 64'(bus.pg_abort_o), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    bus.req_i       = '0;
    bus.req_cnt_i   = '0;
    bus.sync_en_i   = 1'b0;
    bus.sync_tick_i = 1'b0;
    bus.pg_done_i   = 1'b0;
    m_ptr           = NR - 1;
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // All four requesting: strict rotation 0,1,2,3,0.
    gw = 0;
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 1'b0, gw, 1);
      gw = GAP;
    end
    run_txn(4'b0100, 1'b1, gw, 1);
    grant(4'b0010, 1'b0, GAP, 2, z);
    gw = GAP;

    for (int t = 0; t < 60; t++) begin
      logic [NR-1:0] mask;
      mask = NR'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        repeat (GAP + $urandom_range(0, 2)) tick();
        check("idle_busy", 64'(bus.busy_o), 64'(0));
        gw = 0;
      end
      run_txn(mask, ($urandom_range(0, 2) == 0), gw, 0);
      gw = GAP;
    end

`ifdef PGARB_WDOG_EN
    grant(4'b1000, 1'b0, gw, 1, z);
    bus.pg_done_i = 1'b0;
    for (int i = 1; i <= WD; i++) begin
      tick();
      check("wd_abort_early", 64'(bus.pg_abort_o), 64'(0));
      check("wd_err_early", 64'(bus.err_o), 64'(0));
      check("wd_done_early", 64'(bus.done_o), 64'(0));
      check("wd_busy", 64'(bus.busy_o), 64'(1));
    end
    tick();
    check("wd_abort", 64'(bus.pg_abort_o), 64'(1));
    check("wd_err", 64'(bus.err_o), 64'(1));
    check("wd_done", 64'(bus.done_o), 64'(oh(cur_w)));
    grant(4'b0001, 1'b0, GAP, 1, z);
    run_to_done(WD);
`else
    grant(4'b1000, 1'b0, gw, 1, z);
    run_to_done(3 * WD);
`endif
    gw = GAP;

    // Asynchronous reset in the middle of a pulse.
    grant(4'b0100, 1'b0, gw, 1, z);
    bus.pg_done_i = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = NR - 1;
    tick();
    run_txn(4'b1010, 1'b0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
